// File: rtl/cnt_pkg.sv
// Shared constants and types for the toggle-cell up/down counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnt_pkg;

    localparam int CNT_WIDTH_DEF = 4;
    localparam int CNT_MOD_DEF   = 10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/tff_cell.sv
// Single-bit toggle storage element: q flips on a clk edge when t is high.
// Latency: one clk edge from t to q.
// Backpressure: none; t is sampled on every edge.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // Toggle on t, async clear on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MOD up/down counter stored in toggle cells, with load, terminal count and wrap pulse.
// Latency: q updates on the clk edge after en/load; tc is combinational; wrap is registered (one edge).
// Backpressure: none; every enabled edge steps. Define CNT_SAT_EN to saturate at the limits instead of wrapping.
module tff_updown_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF,
    parameter int MOD   = CNT_MOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Terminal values; the extended modulus lets MOD == 2**WIDTH compare correctly.
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] Q_ZERO  = '0;
    localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    dir_e             dir;
    logic             at_max;
    logic             at_zero;
    logic             din_ok;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] t_vec;
    logic             wrap_nxt;

    assign dir     = dir_e'(up);
    assign at_max  = (q == Q_MAX);
    assign at_zero = (q == Q_ZERO);
    assign din_ok  = ({1'b0, din} < MOD_EXT);

    // Next count: load beats count, out-of-range loads collapse to zero.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = din_ok ? din : Q_ZERO;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (at_max) begin
`ifdef CNT_SAT_EN
                    q_nxt    = Q_MAX;
`else
                    q_nxt    = Q_ZERO;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q + Q_ONE;
                end
            end else begin
                if (at_zero) begin
`ifdef CNT_SAT_EN
                    q_nxt    = Q_ZERO;
`else
                    q_nxt    = Q_MAX;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q - Q_ONE;
                end
            end
        end
    end

    // Toggle vector: each bit flips exactly where the next count differs.
    assign t_vec = q ^ q_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (t_vec[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

    // Terminal count: gated off during reset and load edges.
    always_comb begin
        tc = en & ~load & ~rst & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_zero));
    end

`ifdef CNT_SAT_EN
    // Saturating build never wraps.
    assign wrap = 1'b0;
    logic unused_wrap;
    assign unused_wrap = wrap_nxt;
`else
    // One-edge wrap pulse, re-armed every edge so back-to-back wraps stay high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end
`endif

endmodule
